jtag_mem_ctrl: RTL and testbench

System-clock-domain consumer of TAP register updates. It sits directly downstream of the JTAG TAP controller, which drives the address, write data and command together with a request toggle.
- Synchronizes the request, executes one read or write on a generic memory port, and returns read data, BUSY/OKAY/ERR status and an acknowledge toggle.
- The TAP samples status through SET_DATA captures.

---
 rtl/jtag_pkg.sv | 24 ++
 rtl/jtag_sync2.sv | 31 +++
 rtl/jtag_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_jtag_mem_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG memory-access path: status and command
// encodings and the memory-controller FSM state type (also used by the TAP side).
package jtag_pkg;

    localparam logic [1:0] StatusBusy = 2'b01;
    localparam logic [1:0] StatusOkay = 2'b10;
    localparam logic [1:0] StatusErr  = 2'b11;

    localparam logic [1:0] CmdRead  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRd,
        StDone
    } jtag_state_e;

    // True for commands that touch memory; 00/11 are acknowledged without access.
    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == CmdRead) || (cmd == CmdWrite);
    endfunction

endpackage

// File: rtl/jtag_sync2.sv
// Two-flop synchronizer for quasi-static or toggle signals crossing into clk.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module jtag_sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/jtag_mem_ctrl.sv
// System-clock consumer of TAP register updates. A toggle on jtag_req_tgl
// launches one read or write on a generic req/gnt/rvalid memory port; the
// result is reported via jtag_status / jtag_rdata and a toggle on jtag_ack_tgl.
// Ports:
//   clk, sys_rst_n          - system clock, asynchronous active-low reset
//   jtag_req_tgl            - request toggle from the TCK domain (asynchronous)
//   jtag_addr/wdata/cmd     - quasi-static request fields, captured on detection
//   jtag_ack_tgl            - toggles once per completed request
//   jtag_rdata, jtag_status - last good read data, BUSY/OKAY/ERR status
//   mem_req/we/addr/wdata   - memory request, held until mem_gnt
//   mem_gnt, mem_rvalid     - request accepted, read data valid
//   mem_rdata               - read data
module jtag_mem_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              jtag_req_tgl,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic [1:0]        jtag_cmd,
    output logic              jtag_ack_tgl,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic [1:0]        jtag_status,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    jtag_state_e       state_q, state_d;
    logic              req_sync;
    logic              req_seen_q;
    logic              launch_q;   // captured fields are ready to be decoded
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [15:0]       tmo_cnt_q;
    logic [1:0]        result_q;
    logic [1:0]        status_q;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              pending;
    logic              tmo_hit;

    jtag_sync2 #(
        .Width(1)
    ) u_req_sync (
        .clk  (clk),
        .rst_n(sys_rst_n),
        .d    (jtag_req_tgl),
        .q    (req_sync)
    );

    assign pending = req_sync != req_seen_q;
    // >= rather than ==: a read granted on the last REQ cycle enters WAIT_RD
    // already past the limit and must still time out.
    assign tmo_hit = tmo_cnt_q >= 16'(TIMEOUT - 1);

    // State register
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completing events take priority over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (launch_q && is_access(cmd_q)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d = (cmd_q == CmdWrite) ? StDone : StWaitRd;
                end else if (tmo_hit) begin
                    state_d = StDone;
                end
            end
            StWaitRd: begin
                if (mem_rvalid || tmo_hit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        if (state_q == StReq) begin
            mem_req = 1'b1;
            mem_we  = cmd_q == CmdWrite;
        end
    end

    // Request capture, timeout counter and result registers
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            req_seen_q <= 1'b0;
            launch_q   <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tmo_cnt_q  <= '0;
            result_q   <= StatusOkay;
            status_q   <= StatusOkay;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            launch_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (launch_q) begin
                        if (is_access(cmd_q)) begin
                            status_q  <= StatusBusy;
                            tmo_cnt_q <= '0;
                        end else begin
                            ack_q <= ~ack_q;
                        end
                    end else if (pending) begin
                        req_seen_q <= req_sync;
                        cmd_q      <= jtag_cmd;
                        addr_q     <= jtag_addr;
                        wdata_q    <= jtag_wdata;
                        launch_q   <= 1'b1;
                    end
                end
                StReq: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    // Only consumed on the way to DONE; a read grant is overwritten later.
                    result_q  <= mem_gnt ? StatusOkay : StatusErr;
                end
                StWaitRd: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    result_q  <= mem_rvalid ? StatusOkay : StatusErr;
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                    end
                end
                StDone: begin
                    status_q <= result_q;
                    ack_q    <= ~ack_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign jtag_ack_tgl = ack_q;
    assign jtag_rdata   = rdata_q;
    assign jtag_status  = status_q;

endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// Directed bench for jtag_mem_ctrl; edge numbers count from the first clk
// edge after the request toggle (edge 0).
module tb_jtag_mem_ctrl;
    import jtag_pkg::*;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              sys_rst_n;
    logic              jtag_req_tgl;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jtag_wdata;
    logic [1:0]        jtag_cmd;
    logic              jtag_ack_tgl;
    logic [DATA_W-1:0] jtag_rdata;
    logic [1:0]        jtag_status;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem_model [256];

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the last run_access call
    int                r_first_req;
    int                r_req_cycles;
    int                r_ack_edge;
    int                r_extra;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_st3;
    logic [1:0]        r_st_pre;

    jtag_mem_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .sys_rst_n   (sys_rst_n),
        .jtag_req_tgl(jtag_req_tgl),
        .jtag_addr   (jtag_addr),
        .jtag_wdata  (jtag_wdata),
        .jtag_cmd    (jtag_cmd),
        .jtag_ack_tgl(jtag_ack_tgl),
        .jtag_rdata  (jtag_rdata),
        .jtag_status (jtag_status),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One TAP request. gnt_after: mem_req cycles until grant (0 = never);
    // rv_after: cycles from grant to rvalid for reads. Memory served from mem_model.
    task automatic run_access(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, input int gnt_after,
                              input int rv_after);
        logic              ack0;
        logic              ack1;
        logic [1:0]        prev_st;
        logic [ADDR_W-1:0] gnt_addr;
        int                gnt_edge;
        jtag_cmd     = cmd;
        jtag_addr    = addr;
        jtag_wdata   = wdata;
        ack0         = jtag_ack_tgl;
        prev_st      = jtag_status;
        gnt_edge     = -1;
        gnt_addr     = '0;
        r_first_req  = -1;
        r_req_cycles = 0;
        r_ack_edge   = -1;
        r_extra      = 0;
        r_we         = 1'b0;
        r_addr       = '0;
        r_wdata      = '0;
        r_st3        = 2'b00;
        r_st_pre     = 2'b00;
        jtag_req_tgl = ~jtag_req_tgl;
        for (int e = 0; e < 40; e++) begin
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (e == 3) r_st3 = jtag_status;
            if (jtag_ack_tgl != ack0) begin
                r_ack_edge = e;
                r_st_pre   = prev_st;
                break;
            end
            prev_st = jtag_status;
            if (mem_req) begin
                if (r_first_req < 0) begin
                    r_first_req = e;
                    r_we        = mem_we;
                    r_addr      = mem_addr;
                    r_wdata     = mem_wdata;
                end
                r_req_cycles++;
                if (gnt_after > 0 && r_req_cycles >= gnt_after) begin
                    mem_gnt  = 1'b1;
                    gnt_edge = e;
                    gnt_addr = mem_addr;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                end
            end
            if (gnt_edge >= 0 && cmd == CmdRead && e == gnt_edge + rv_after) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_model[gnt_addr];
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        ack1       = jtag_ack_tgl;
        repeat (4) begin
            tick();
            if (jtag_ack_tgl != ack1) r_extra++;
            if (mem_req) r_req_cycles++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        sys_rst_n    = 1'b0;
        jtag_req_tgl = 1'b0;
        jtag_addr    = '0;
        jtag_wdata   = '0;
        jtag_cmd     = 2'b00;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        repeat (3) tick();

        // Reset values
        check_eq("rst_ack", 32'(jtag_ack_tgl), 0);
        check_eq("rst_rdata", 32'(jtag_rdata), 0);
        check_eq("rst_status", 32'(jtag_status), 2);
        check_eq("rst_mem_req", 32'(mem_req), 0);
        check_eq("rst_mem_we", 32'(mem_we), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 0);
        sys_rst_n = 1'b1;
        repeat (3) tick();

        // 1: write with immediate grant
        run_access(CmdWrite, 8'h3F, 16'h7E81, 1, 0);
        check_eq("t1_first_req_edge", r_first_req, 3);
        check_eq("t1_req_cycles", r_req_cycles, 1);
        check_eq("t1_we", 32'(r_we), 1);
        check_eq("t1_addr", 32'(r_addr), 32'h3F);
        check_eq("t1_wdata", 32'(r_wdata), 32'h7E81);
        check_eq("t1_status_e3", 32'(r_st3), 1);
        check_eq("t1_ack_edge", r_ack_edge, 5);
        check_eq("t1_status", 32'(jtag_status), 2);
        check_eq("t1_extra_ack", r_extra, 0);

        // 2: read, grant on third req cycle, rvalid two cycles after grant
        mem_model[8'h3F] = 16'h7E81;
        run_access(CmdRead, 8'h3F, 16'h0000, 3, 2);
        check_eq("t2_req_cycles", r_req_cycles, 3);
        check_eq("t2_we", 32'(r_we), 0);
        check_eq("t2_ack_edge", r_ack_edge, 9);
        check_eq("t2_busy_before_ack", 32'(r_st_pre), 1);
        check_eq("t2_rdata", 32'(jtag_rdata), 32'h7E81);
        check_eq("t2_status", 32'(jtag_status), 2);
        check_eq("t2_extra_ack", r_extra, 0);

        // 4: no-access command
        run_access(2'b00, 8'h11, 16'h2222, 1, 1);
        check_eq("t4_req_cycles", r_req_cycles, 0);
        check_eq("t4_ack_edge", r_ack_edge, 3);
        check_eq("t4_status", 32'(jtag_status), 2);
        check_eq("t4_rdata", 32'(jtag_rdata), 32'h7E81);

        // 3: read never granted -> timeout
        mem_model[8'h10] = 16'hDEAD;
        run_access(CmdRead, 8'h10, 16'h0000, 0, 1);
        check_eq("t3_req_cycles", r_req_cycles, TIMEOUT);
        check_eq("t3_ack_edge", r_ack_edge, 12);
        check_eq("t3_busy_before_ack", 32'(r_st_pre), 1);
        check_eq("t3_status", 32'(jtag_status), 3);
        check_eq("t3_rdata", 32'(jtag_rdata), 32'h7E81);

        // cmd 11 leaves the ERR status in place
        run_access(2'b11, 8'h12, 16'h3333, 1, 1);
        check_eq("t3b_ack_edge", r_ack_edge, 3);
        check_eq("t3b_status", 32'(jtag_status), 3);

        // 5: reset while in REQ
        jtag_cmd     = CmdRead;
        jtag_addr    = 8'h22;
        jtag_req_tgl = ~jtag_req_tgl;
        repeat (4) tick();
        check_eq("t5_in_req", 32'(mem_req), 1);
        sys_rst_n = 1'b0;
        #1;
        check_eq("t5_mem_req_async", 32'(mem_req), 0);
        check_eq("t5_ack", 32'(jtag_ack_tgl), 0);
        check_eq("t5_status", 32'(jtag_status), 2);
        check_eq("t5_rdata", 32'(jtag_rdata), 0);
        check_eq("t5_mem_addr", 32'(mem_addr), 0);
        jtag_req_tgl = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        begin
            int spurious = 0;
            repeat (6) begin
                tick();
                if (jtag_ack_tgl != 1'b0 || mem_req) spurious++;
            end
            check_eq("t5_no_ack_after_release", spurious, 0);
        end
        run_access(CmdWrite, 8'h77, 16'hABCD, 1, 0);
        check_eq("t5_write_ack_edge", r_ack_edge, 5);
        check_eq("t5_write_status", 32'(jtag_status), 2);
        check_eq("t5_write_mem", 32'(mem_model[8'h77]), 32'hABCD);

        // 6: back-to-back write then read of the same address
        run_access(CmdWrite, 8'h5A, 16'h1234, 1, 0);
        check_eq("t6_wr_ack_edge", r_ack_edge, 5);
        check_eq("t6_wr_req_cycles", r_req_cycles, 1);
        run_access(CmdRead, 8'h5A, 16'h0000, 1, 1);
        check_eq("t6_rd_ack_edge", r_ack_edge, 6);
        check_eq("t6_rd_req_cycles", r_req_cycles, 1);
        check_eq("t6_rdata", 32'(jtag_rdata), 32'h1234);
        check_eq("t6_status", 32'(jtag_status), 2);
        check_eq("t6_extra_ack", r_extra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
